// File: rtl/regfile_pkg.sv
// Register file geometry shared by the regfile, decode and write-back arbiter.
package regfile_pkg;
  localparam int REG_W     = 32;
  localparam int REG_WORDS = 32;
  localparam int REG_AW    = $clog2(REG_WORDS);
  localparam logic [REG_W-1:0] ZERO_IDX = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer marks the highest-priority index and moves
// just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

  assign ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset)        ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NREQ write-back sources through
// a round-robin grant and a registered output stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int WORDS    = REG_WORDS,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*REG_W-1:0]   req_addr,
  input  logic [NREQ*REG_W-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wb_stall,
  output logic                    wr_en,
  output logic [REG_W-1:0]        wr_addr,
  output logic [REG_W-1:0]        wr_data,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int AW = $clog2(WORDS);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]  elig;
  logic [GW-1:0]    gidx;
  logic             xfer;
  logic [REG_W-1:0] addr_trunc;
  logic             wr_en_d, wr_en_q;
  logic [REG_W-1:0] wr_addr_q, wr_data_q;
  logic [GW-1:0]    grant_id_q;

  // Stall and reset empty the eligible set so nothing is consumed.
  assign elig = (reset || wb_stall) ? '0 : req_valid;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (xfer),
    .gnt     (req_ready),
    .gnt_idx (gidx)
  );

  assign xfer       = |req_ready;
  assign addr_trunc = {{(REG_W-AW){1'b0}}, req_addr[int'(gidx)*REG_W +: AW]};
  // Writes to the zero register are still consumed, just never enabled.
  assign wr_en_d    = xfer && !(ZERO_REG && (addr_trunc == ZERO_IDX));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (xfer) begin
        wr_addr_q  <= addr_trunc;
        wr_data_q  <= req_data[int'(gidx)*REG_W +: REG_W];
        grant_id_q <= gidx;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, WORDS=32, ZERO_REG=1).
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wb_stall;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [1:0]        grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .WORDS(32), .ZERO_REG(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_stall  (wb_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's request pattern and check the combinational grant.
  task automatic cyc(input string tag, input logic [2:0] v, input logic st,
                     input logic [2:0] exp_rdy);
    req_valid = v;
    wb_stall  = st;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    step();
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [1:0] gid,
                         input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_wr_en"},   64'(wr_en),    64'(en));
    chk({tag, "_gid"},     64'(grant_id), 64'(gid));
    chk({tag, "_wr_addr"}, 64'(wr_addr),  64'(addr));
    chk({tag, "_wr_data"}, 64'(wr_data),  64'(data));
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d);
    req_addr[i*32 +: 32] = a;
    req_data[i*32 +: 32] = d;
  endtask

  int ord[7] = '{0, 1, 2, 0, 1, 2, 0};

  initial begin
    reset = 1'b1; wb_stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    step();
    // Ready must stay low while reset is asserted even with requests present.
    req_valid = 3'b111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(3'b000));
    step();
    chk_out("rst", 1'b0, 2'd0, 32'h0, 32'h0);

    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc("idle", 3'b000, 1'b0, 3'b000);
      chk_out("idle", 1'b0, 2'd0, 32'h0, 32'h0);
    end

    // Single requester 1.
    set_req(1, 32'd5, 32'hDEADBEEF);
    cyc("single", 3'b010, 1'b0, 3'b010);
    chk_out("single", 1'b1, 2'd1, 32'd5, 32'hDEADBEEF);

    // Fresh reset so the pointer starts at 0 for the fairness run.
    reset = 1'b1; req_valid = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(8 + i), 32'hA000_0000 + 32'(i));
    for (int k = 0; k < 7; k++) begin
      cyc("fair", 3'b111, 1'b0, 3'(1 << ord[k]));
      chk_out("fair", 1'b1, 2'(ord[k]), 32'(8 + ord[k]), 32'hA000_0000 + 32'(ord[k]));
    end

    // Stall two cycles under full load; outputs keep the last write's fields.
    cyc("stall1", 3'b111, 1'b1, 3'b000);
    chk_out("stall1", 1'b0, 2'd0, 32'd8, 32'hA000_0000);
    cyc("stall2", 3'b111, 1'b1, 3'b000);
    chk_out("stall2", 1'b0, 2'd0, 32'd8, 32'hA000_0000);
    cyc("resume1", 3'b111, 1'b0, 3'b010);
    chk_out("resume1", 1'b1, 2'd1, 32'd9, 32'hA000_0001);
    cyc("resume2", 3'b111, 1'b0, 3'b100);
    chk_out("resume2", 1'b1, 2'd2, 32'd10, 32'hA000_0002);

    // Lone requester 2 is granted every cycle whatever the pointer is.
    for (int k = 0; k < 3; k++) begin
      cyc("lone", 3'b100, 1'b0, 3'b100);
      chk_out("lone", 1'b1, 2'd2, 32'd10, 32'hA000_0002);
    end

    // Address 0x20 truncates to register 0: consumed but not enabled.
    set_req(1, 32'h20, 32'h5555_AAAA);
    cyc("zero", 3'b010, 1'b0, 3'b010);
    chk_out("zero", 1'b0, 2'd1, 32'h0, 32'h5555_AAAA);

    set_req(1, 32'h25, 32'h1234_5678);
    cyc("trunc", 3'b010, 1'b0, 3'b010);
    chk_out("trunc", 1'b1, 2'd1, 32'd5, 32'h1234_5678);

    // Reset arriving with a full load: no grant, outputs cleared, pointer to 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(16 + i), 32'hB000_0000 + 32'(i));
    reset = 1'b1;
    cyc("midrst", 3'b111, 1'b0, 3'b000);
    chk_out("midrst", 1'b0, 2'd0, 32'h0, 32'h0);
    reset = 1'b0;
    cyc("postrst", 3'b111, 1'b0, 3'b001);
    chk_out("postrst", 1'b1, 2'd0, 32'd16, 32'hB000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the CPU register file. It shares the register file's single write port (write_en / w0_addr / w0) between NREQ independent write-back sources, such as the ALU, load unit and multiplier. It grants at most one source per cycle using round-robin priority and drives the register file write port from a registered output stage. It sits between the execute/memory units and the register file.

## Interface

Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- WORDS, 32, register file depth; AW = $clog2(WORDS) significant address bits
- ZERO_REG, 1, when 1, writes to address 0 are accepted but never reach the register file

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*32  packed destination addresses; requester i occupies bits [32*i+31:32*i]
- req_data  input  NREQ*32  packed write data, same packing as req_addr
- req_ready  output  NREQ  one-hot or zero; combinational grant, transfer occurs when req_valid[i] & req_ready[i]
- wb_stall  input  1  when high, no grant is issued this cycle
- wr_en  output  1  to register file write_en
- wr_addr  output  32  to register file w0_addr; bits [31:AW] always 0
- wr_data  output  32  to register file w0
- grant_id  output  $clog2(NREQ)  index of the requester whose write is on wr_*, valid when wr_en=1

## Operation

- Eligible set: requesters with req_valid[i]=1. wb_stall=1 or reset=1 forces an empty eligible set.
- Round-robin selection:
  - Priority pointer ptr holds the index with highest priority.
  - The first eligible index scanning ptr, ptr+1, … modulo NREQ wins.
  - req_ready[winner]=1; all other bits are 0.
- Pointer update: on a transfer to index w, ptr <= (w+1) mod NREQ. With no transfer, ptr holds.
- req_ready may depend combinationally on req_valid and wb_stall. Requesters must not make req_valid depend on req_ready.
- Output stage:
  - On a transfer, wr_addr <= {zeros, req_addr[w][AW-1:0]}, wr_data <= req_data[w], grant_id <= w.
  - wr_en <= 1, except when ZERO_REG=1 and the truncated address is 0; then wr_en <= 0 and the write is still consumed.
  - With no transfer, wr_en <= 0 and wr_addr, wr_data and grant_id hold.
- Address bits [31:AW] of req_addr are ignored.
- Same-address requests from several sources are not merged. They are written in grant order and the last grant wins.
- A requester keeping req_valid high is served at least once every NREQ cycles while wb_stall=0, so no requester starves.

## Timing

- Reset values: ptr=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0. req_ready=0 while reset=1.
- Latency: a transfer in cycle N appears on wr_* in cycle N+1. The register file commits it at the edge ending cycle N+1, so it is readable from cycle N+2 onward.
- Throughput: one write per cycle, sustained.
- wb_stall asserted in cycle N:
  - No transfer in cycle N, so wr_en=0 in cycle N+1.
  - A transfer from cycle N-1 still presents normally in cycle N.
- Reset mid-operation:
  - A transfer accepted in the cycle reset rises is discarded.
  - wr_en=0 from the next cycle.
  - Requesters must re-present the write.
- Simultaneous events:
  - All NREQ requesters valid: the grant follows ptr exactly.
  - Single valid requester: granted every cycle regardless of ptr.

## Structure

- Package regfile_pkg: REG_AW / WORDS defaults, REG_W=32, and the zero-register index constant, shared with regfile and decode.
- Sub-module rr_arbiter (parameter N) is natural and reusable elsewhere:
  - inputs: req[N], advance
  - outputs: gnt[N] one-hot, gnt_idx
  - contains ptr and the pointer-update rule
- regfile_wb_arbiter wraps rr_arbiter with the data mux, the ZERO_REG filter and the output register.

## Test plan

- After reset with no requests: wr_en=0, wr_addr=0, wr_data=0, req_ready=0 → all stay 0 for 5 cycles.
- Single requester: requester 1 sends addr=5, data=0xDEADBEEF in cycle 3 → req_ready=3'b010 in cycle 3; cycle 4 has wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=1.
- Fairness: NREQ=3, all valid for 6 cycles from reset → grant order 0,1,2,0,1,2 with one write per cycle and no gaps.
- Stall: wb_stall held high for 2 cycles under full load → req_ready=0 and wr_en=0 one cycle later; ptr is preserved and the order resumes where it stopped.
- Zero register and truncation:
  - addr=0 with ZERO_REG=1 → consumed (ready=1), wr_en=0 next cycle.
  - addr=0x25, WORDS=32 → wr_addr=5.
- Reset mid-operation: reset asserted in the same cycle as a grant → wr_en=0 next cycle and ptr=0.
